freq_measure_sequencer: RTL

FREQ_MEASURE_SEQUENCER -- requirements
Module: freq_measure_sequencer

---
 rtl/freq_measure_sequencer_if.sv | 28 ++
 rtl/freq_measure_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_measure_sequencer_if.sv
// Control and result handshake bundle for freq_measure_sequencer.
// The master side issues start/abort and accepts results; the slave side is the sequencer.
`timescale 1ns/1ps
interface freq_measure_sequencer_if #(
    parameter int NUM_CHANNELS = 4
);
    localparam int CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0] chan_en;
    logic                    start;
    logic                    abort;
    logic                    busy;
    logic                    result_valid;
    logic                    result_ready;
    logic [CHAN_W-1:0]       result_chan;
    logic [31:0]             result_count;
    logic                    result_sat;

    modport master (
        output chan_en, start, abort, result_ready,
        input  busy, result_valid, result_chan, result_count, result_sat
    );

    modport slave (
        input  chan_en, start, abort, result_ready,
        output busy, result_valid, result_chan, result_count, result_sat
    );
endinterface

// File: rtl/freq_measure_sequencer.sv
// Scans enabled oscillator inputs with one shared edge counter: settle, gate, report per channel.
// Define FREQ_SEQ_CONTINUOUS_EN to wrap each pass back to the lowest enabled channel until abort.
`timescale 1ns/1ps
module freq_measure_sequencer #(
    parameter int NUM_CHANNELS  = 4,
    parameter int GATE_CYCLES   = 100000,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NUM_CHANNELS-1:0] in_signal,
    freq_measure_sequencer_if.slave bus
);
    localparam int          CW          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] GATE_LAST   = 32'(GATE_CYCLES - 1);
    localparam logic [31:0] COUNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_GATE   = 3'd2,
        ST_STORE  = 3'd3,
        ST_NEXT   = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [1:0]              arm_sync_r;
    logic [NUM_CHANNELS-1:0] mask_r;
    logic [CW-1:0]           chan_r;
    logic [CW-1:0]           chan_next_s;
    logic [31:0]             timer_r;
    logic [31:0]             count_r;
    logic [31:0]             count_next_s;
    logic                    sat_r;
    logic                    sat_next_s;
    logic [1:0]              in_sync_r;
    logic                    edge_prev_r;
    logic                    edge_s;
    logic                    sel_in_s;
    logic                    enter_settle_s;
    logic                    enter_gate_s;
    logic                    enter_store_s;
    logic                    load_mask_s;
    logic                    busy_r;
    logic                    result_valid_r;
    logic [CW-1:0]           result_chan_r;
    logic [31:0]             result_count_r;
    logic                    result_sat_r;
    logic [CW:0]             first_en_s;
    logic [CW:0]             next_en_s;
`ifdef FREQ_SEQ_CONTINUOUS_EN
    logic [CW:0]             wrap_en_s;
`endif

    // Lowest set bit of mask at or above index lo, returned as {found, index}.
    function automatic logic [CW:0] find_enabled(input logic [NUM_CHANNELS-1:0] mask, input int lo);
        logic [CW:0] hit;
        hit = {(CW + 1){1'b0}};
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            hit = ((i >= lo) && mask[i]) ? {1'b1, CW'(i)} : hit;
        end
        return hit;
    endfunction

    assign first_en_s = find_enabled(bus.chan_en, 0);
    assign next_en_s  = find_enabled(mask_r, int'(chan_r) + 1);
`ifdef FREQ_SEQ_CONTINUOUS_EN
    assign wrap_en_s  = find_enabled(mask_r, 0);
`endif

    assign sel_in_s = in_signal[chan_r];
    assign edge_s   = in_sync_r[1] & ~edge_prev_r;

    // Start is only honoured once reset release has crossed two flops of clk.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arm_sync_r <= 2'b00;
        end else begin
            arm_sync_r <= {arm_sync_r[0], 1'b1};
        end
    end

    // Next-state decode; abort wins over everything including start.
    always_comb begin
        state_next_s   = state_r;
        chan_next_s    = chan_r;
        enter_settle_s = 1'b0;
        enter_gate_s   = 1'b0;
        enter_store_s  = 1'b0;
        load_mask_s    = 1'b0;
        if (bus.abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && arm_sync_r[1] && first_en_s[CW]) begin
                        state_next_s   = ST_SETTLE;
                        chan_next_s    = first_en_s[CW-1:0];
                        enter_settle_s = 1'b1;
                        load_mask_s    = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_r == SETTLE_LAST) begin
                        state_next_s = ST_GATE;
                        enter_gate_s = 1'b1;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end
                ST_GATE: begin
                    if (timer_r == GATE_LAST) begin
                        state_next_s  = ST_STORE;
                        enter_store_s = 1'b1;
                    end else begin
                        state_next_s = ST_GATE;
                    end
                end
                ST_STORE: begin
                    if (result_valid_r && bus.result_ready) begin
                        state_next_s = ST_NEXT;
                    end else begin
                        state_next_s = ST_STORE;
                    end
                end
                ST_NEXT: begin
                    if (next_en_s[CW]) begin
                        state_next_s   = ST_SETTLE;
                        chan_next_s    = next_en_s[CW-1:0];
                        enter_settle_s = 1'b1;
                    end else begin
`ifdef FREQ_SEQ_CONTINUOUS_EN
                        state_next_s   = ST_SETTLE;
                        chan_next_s    = wrap_en_s[CW-1:0];
                        enter_settle_s = 1'b1;
`else
                        state_next_s   = ST_IDLE;
`endif
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Saturating edge count; an edge arriving at the ceiling is lost and flagged.
    always_comb begin
        count_next_s = count_r;
        sat_next_s   = sat_r;
        if ((state_r == ST_GATE) && edge_s) begin
            if (count_r == COUNT_MAX) begin
                sat_next_s = 1'b1;
            end else begin
                count_next_s = count_r + 32'd1;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // State register with busy derived from the next state so both change together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Channel pointer and the mask snapshot taken at start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mask_r <= {NUM_CHANNELS{1'b0}};
            chan_r <= {CW{1'b0}};
        end else if (load_mask_s) begin
            mask_r <= bus.chan_en;
            chan_r <= chan_next_s;
        end else begin
            mask_r <= mask_r;
            chan_r <= chan_next_s;
        end
    end

    // Synchronizer and edge detector restart from zero whenever a channel is (re)selected.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_sync_r   <= 2'b00;
            edge_prev_r <= 1'b0;
        end else if (enter_settle_s) begin
            in_sync_r   <= 2'b00;
            edge_prev_r <= 1'b0;
        end else begin
            in_sync_r   <= {in_sync_r[0], sel_in_s};
            edge_prev_r <= in_sync_r[1];
        end
    end

    // Phase timer: restarts on every state change, advances only in SETTLE and GATE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_r <= 32'd0;
        end else if (state_next_s != state_r) begin
            timer_r <= 32'd0;
        end else if ((state_r == ST_SETTLE) || (state_r == ST_GATE)) begin
            timer_r <= timer_r + 32'd1;
        end else begin
            timer_r <= timer_r;
        end
    end

    // Shared edge counter, cleared on abort and at the start of each gate window.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r <= 32'd0;
            sat_r   <= 1'b0;
        end else if (bus.abort || enter_gate_s) begin
            count_r <= 32'd0;
            sat_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            sat_r   <= sat_next_s;
        end
    end

    // Result registers capture the count including an edge on the final gate cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            result_valid_r <= 1'b0;
            result_chan_r  <= {CW{1'b0}};
            result_count_r <= 32'd0;
            result_sat_r   <= 1'b0;
        end else if (bus.abort) begin
            result_valid_r <= 1'b0;
            result_chan_r  <= {CW{1'b0}};
            result_count_r <= 32'd0;
            result_sat_r   <= 1'b0;
        end else if (enter_store_s) begin
            result_valid_r <= 1'b1;
            result_chan_r  <= chan_r;
            result_count_r <= count_next_s;
            result_sat_r   <= sat_next_s;
        end else if (result_valid_r && bus.result_ready) begin
            result_valid_r <= 1'b0;
            result_chan_r  <= result_chan_r;
            result_count_r <= result_count_r;
            result_sat_r   <= result_sat_r;
        end else begin
            result_valid_r <= result_valid_r;
            result_chan_r  <= result_chan_r;
            result_count_r <= result_count_r;
            result_sat_r   <= result_sat_r;
        end
    end

    assign bus.busy         = busy_r;
    assign bus.result_valid = result_valid_r;
    assign bus.result_chan  = result_chan_r;
    assign bus.result_count = result_count_r;
    assign bus.result_sat   = result_sat_r;
endmodule
